ra_2r1w_32x32_bist: RTL and testbench

Built-in self-test initiator for the 2-read/1-write 32x32 SDR register-file wrapper. Drives the wrapper's read and write request ports, then checks returned read data against expected values on both read ports. Runs a four-sweep march: write background, read background, write inverse, read inverse. Sits beside the wrapper and is muxed onto its request ports during test.

---
 rtl/ra_2r1w_32x32_bist.sv | 165 ++++++++++++++++
 tb/tb_ra_2r1w_32x32_bist.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ra_2r1w_32x32_bist.sv
// March-test initiator for the 2R/1W 32x32 register-file wrapper: write/read a
// background and its inverse, compare both read ports, and log the first miscompare.
module ra_2r1w_32x32_bist #(
  parameter int LATCHRD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [0:31] bg,
  output logic        rd_enb_0,
  output logic [0:4]  rd_adr_0,
  input  logic [0:31] rd_dat_0,
  output logic        rd_enb_1,
  output logic [0:4]  rd_adr_1,
  input  logic [0:31] rd_dat_1,
  output logic        wr_enb_0,
  output logic [0:4]  wr_adr_0,
  output logic [0:31] wr_dat_0,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [0:7]  fail_cnt,
  output logic [0:4]  fail_adr,
  output logic        fail_port,
  output logic        fail_phase,
  output logic [0:31] fail_dat
);
  localparam int RDLAT     = 1 + LATCHRD;
  localparam int DRAIN_CYC = RDLAT + 2;

  typedef enum logic [2:0] {IDLE, WR_BG, RD_BG, WR_INV, RD_INV, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [4:0] adr0;
    logic [4:0] adr1;
    logic       ph;
  } chk_t;

  state_t            state, ret_state;
  logic [4:0]        cnt;
  logic [31:0]       bgq;
  logic              rd_ph;
  logic [RDLAT:1]    vld_pipe;
  chk_t [RDLAT:1]    chk_pipe;
  logic [1:0]        miss;
  logic [8:0]        cnt_sum;

  // Address term folded into the expected word exposes decoder aliasing.
  function automatic logic [31:0] exp_word(input logic [4:0] a, input logic inv);
    return (inv ? ~bgq : bgq) ^ {27'b0, a};
  endfunction

  always_comb begin
    miss = '0;
    if (vld_pipe[RDLAT]) begin
      miss[0] = (rd_dat_0 != exp_word(chk_pipe[RDLAT].adr0, chk_pipe[RDLAT].ph));
      miss[1] = (rd_dat_1 != exp_word(chk_pipe[RDLAT].adr1, chk_pipe[RDLAT].ph));
    end
  end

  assign cnt_sum = {1'b0, fail_cnt} + {8'b0, miss[0]} + {8'b0, miss[1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      cnt        <= '0;
      bgq        <= '0;
      rd_ph      <= 1'b0;
      vld_pipe   <= '0;
      chk_pipe   <= '0;
      rd_enb_0   <= 1'b0;
      rd_adr_0   <= '0;
      rd_enb_1   <= 1'b0;
      rd_adr_1   <= '0;
      wr_enb_0   <= 1'b0;
      wr_adr_0   <= '0;
      wr_dat_0   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_cnt   <= '0;
      fail_adr   <= '0;
      fail_port  <= 1'b0;
      fail_phase <= 1'b0;
      fail_dat   <= '0;
    end else begin
      rd_enb_0 <= 1'b0;
      rd_enb_1 <= 1'b0;
      wr_enb_0 <= 1'b0;

      // Check pipe tracks the request flops; stage RDLAT lines up with rd_dat_*.
      vld_pipe[1] <= rd_enb_0;
      chk_pipe[1] <= {rd_adr_0, rd_adr_1, rd_ph};
      for (int k = 2; k <= RDLAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        chk_pipe[k] <= chk_pipe[k-1];
      end

      if (miss != 2'b00) begin
        fail     <= 1'b1;
        fail_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        if (!fail) begin
          fail_phase <= chk_pipe[RDLAT].ph;
          fail_port  <= !miss[0];
          fail_adr   <= miss[0] ? chk_pipe[RDLAT].adr0 : chk_pipe[RDLAT].adr1;
          fail_dat   <= miss[0] ? rd_dat_0 : rd_dat_1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            bgq        <= bg;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_cnt   <= '0;
            fail_adr   <= '0;
            fail_port  <= 1'b0;
            fail_phase <= 1'b0;
            fail_dat   <= '0;
            cnt        <= '0;
            state      <= WR_BG;
          end else if (state == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        WR_BG, WR_INV: begin
          wr_enb_0 <= 1'b1;
          wr_adr_0 <= cnt;
          wr_dat_0 <= exp_word(cnt, state == WR_INV);
          cnt      <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            cnt       <= '0;
            ret_state <= (state == WR_BG) ? RD_BG : RD_INV;
            state     <= DRAIN;
          end
        end
        RD_BG, RD_INV: begin
          rd_enb_0 <= 1'b1;
          rd_enb_1 <= 1'b1;
          rd_adr_0 <= cnt;
          rd_adr_1 <= ~cnt;
          rd_ph    <= (state == RD_INV);
          cnt      <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            cnt       <= '0;
            ret_state <= (state == RD_BG) ? WR_INV : DONE;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DRAIN_CYC - 1)) begin
            cnt   <= '0;
            state <= ret_state;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ra_2r1w_32x32_bist.sv
// Bench for the register-file BIST: two instances (LATCHRD=1/0), each with a
// behavioural wrapper model that can inject stuck bits, aliasing or global corruption.
module tb_ra_2r1w_32x32_bist;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] st = '0;
  logic [0:31] bg = '0;
  logic clr_mem = 1'b0;
  int fault = 0;
  bit sel = 1'b1;
  int total = 0, bad = 0, cur = 0;

  always #5 clk = ~clk;

  logic        re0 [2], re1 [2], we [2];
  logic [0:4]  ra0 [2], ra1 [2], wa [2];
  logic [0:31] wd [2];
  logic        busy [2], done [2], fail [2], fport [2], fph [2];
  logic [0:7]  fcnt [2];
  logic [0:4]  fadr [2];
  logic [0:31] fdat [2];

  // fault 1: word4 bit31 stuck-1; 2: writes to 7 land in 23; 3: words 3/28 bit0 stuck-1;
  // 4: bit0 of every read flipped; 5: word30 bit0 stuck-1
  function automatic logic [0:4] wmap(input logic [0:4] a);
    return (fault == 2 && a == 5'd7) ? 5'd23 : a;
  endfunction

  function automatic logic [0:31] rdata(input logic [0:4] a, input logic [0:31] d);
    logic [0:31] r;
    r = d;
    case (fault)
      1: if (a == 5'd4) r[31] = 1'b1;
      3: if (a == 5'd3 || a == 5'd28) r[0] = 1'b1;
      4: r[0] = ~r[0];
      5: if (a == 5'd30) r[0] = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [0:31] mem [32];
    logic [0:31] rq0, rq1, rl0, rl1, dat0, dat1;

    always @(posedge clk) begin
      if (clr_mem) begin
        for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (we[g]) begin
        mem[wmap(wa[g])] <= wd[g];
      end
      rq0 <= rdata(ra0[g], mem[ra0[g]]);
      rq1 <= rdata(ra1[g], mem[ra1[g]]);
      rl0 <= rq0;
      rl1 <= rq1;
    end

    assign dat0 = (g == 1) ? rl0 : rq0;
    assign dat1 = (g == 1) ? rl1 : rq1;

    ra_2r1w_32x32_bist #(.LATCHRD(g)) u_dut (
      .clk(clk), .reset(reset), .start(st[g]), .bg(bg),
      .rd_enb_0(re0[g]), .rd_adr_0(ra0[g]), .rd_dat_0(dat0),
      .rd_enb_1(re1[g]), .rd_adr_1(ra1[g]), .rd_dat_1(dat1),
      .wr_enb_0(we[g]), .wr_adr_0(wa[g]), .wr_dat_0(wd[g]),
      .busy(busy[g]), .done(done[g]), .fail(fail[g]), .fail_cnt(fcnt[g]),
      .fail_adr(fadr[g]), .fail_port(fport[g]), .fail_phase(fph[g]), .fail_dat(fdat[g])
    );
  end

  typedef struct {
    bit          latch;
    logic [0:31] bg;
    int          fault;
    int          repulse;
    int          cyc;
    bit          fail;
    int          cnt;
    int          adr;
    bit          port;
    bit          ph;
    logic [0:31] dat;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (case %0d): got %0h want %0h", nm, cur, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm, input int g);
    chk({nm, "_stat"}, 64'({busy[g], done[g], fail[g], fcnt[g], fadr[g], fport[g], fph[g], fdat[g]}), 64'd0);
    chk({nm, "_req"}, 64'({re0[g], ra0[g], re1[g], ra1[g], we[g], wa[g], wd[g]}), 64'd0);
  endtask

  task automatic launch(input vec_t v);
    sel = v.latch; fault = v.fault; bg = v.bg;
    clr_mem = 1'b1; @(negedge clk); clr_mem = 1'b0;
    st[sel] = 1'b1; @(negedge clk); st[sel] = 1'b0;
  endtask

  task automatic run(input vec_t v);
    int n, first, p1a, viol;
    launch(v);
    chk("start_clr", 64'({busy[sel], done[sel], fail[sel], fcnt[sel]}), 64'({1'b1, 1'b0, 1'b0, 8'd0}));
    first = -1; p1a = -1; viol = 0;
    for (n = 1; n < 2000; n++) begin
      @(negedge clk);
      if (v.repulse != 0) st[sel] = (n == v.repulse);
      if (first < 0 && (we[sel] || re0[sel] || re1[sel])) first = n;
      if (p1a < 0 && re1[sel]) p1a = int'(ra1[sel]);
      if ((we[sel] && (re0[sel] || re1[sel])) || (re0[sel] != re1[sel]) ||
          (re0[sel] && (int'(ra0[sel]) + int'(ra1[sel]) != 31))) viol++;
      if (done[sel]) break;
    end
    st[sel] = 1'b0;
    chk("cycles", 64'(n - first), 64'(v.cyc));
    chk("busy_end", 64'(busy[sel]), 64'd0);
    chk("fail", 64'(fail[sel]), 64'(v.fail));
    chk("fail_cnt", 64'(fcnt[sel]), 64'(v.cnt));
    chk("fail_adr", 64'(fadr[sel]), 64'(v.adr));
    chk("fail_port", 64'(fport[sel]), 64'(v.port));
    chk("fail_phase", 64'(fph[sel]), 64'(v.ph));
    chk("fail_dat", 64'(fdat[sel]), 64'(v.dat));
    chk("p1_first_adr", 64'(p1a), 64'd31);
    chk("req_rules", 64'(viol), 64'd0);
  endtask

  initial begin
    //          latch bg            flt rep cyc fail cnt adr port ph dat
    tbl[0] = '{1'b1, 32'hA5A5_A5A5, 0, 0,  144, 1'b0, 0,   0,  1'b0, 1'b0, 32'h0000_0000};
    tbl[1] = '{1'b1, 32'h0000_0000, 1, 0,  144, 1'b1, 2,   4,  1'b0, 1'b0, 32'h0000_0005};
    tbl[2] = '{1'b1, 32'hFFFF_FFFF, 2, 0,  144, 1'b1, 4,   7,  1'b0, 1'b0, 32'h0000_0000};
    tbl[3] = '{1'b0, 32'hA5A5_A5A5, 0, 0,  140, 1'b0, 0,   0,  1'b0, 1'b0, 32'h0000_0000};
    tbl[4] = '{1'b1, 32'hFFFF_FFFF, 1, 0,  144, 1'b1, 2,   4,  1'b0, 1'b1, 32'h0000_0005};
    tbl[5] = '{1'b1, 32'h0000_0000, 3, 0,  144, 1'b1, 4,   3,  1'b0, 1'b0, 32'h8000_0003};
    tbl[6] = '{1'b0, 32'h0000_0000, 4, 0,  140, 1'b1, 128, 0,  1'b0, 1'b0, 32'h8000_0000};
    tbl[7] = '{1'b1, 32'h0000_0000, 5, 0,  144, 1'b1, 2,   30, 1'b1, 1'b0, 32'h8000_001E};
    tbl[8] = '{1'b1, 32'h1234_5678, 0, 50, 144, 1'b0, 0,   0,  1'b0, 1'b0, 32'h0000_0000};
    tbl[9] = '{1'b0, 32'hFFFF_FFFF, 1, 0,  140, 1'b1, 2,   4,  1'b0, 1'b1, 32'h0000_0005};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    cur = 99;
    chk_zero("reset0", 0);
    chk_zero("reset1", 1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      cur = i;
      run(tbl[i]);
    end

    // Reset in the middle of the background read sweep with every read corrupted.
    cur = 100;
    launch('{1'b1, 32'h0000_0000, 4, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0});
    repeat (50) @(negedge clk);
    chk("pre_reset_fail", 64'(fail[1]), 64'd1);
    chk("pre_reset_rd", 64'(re0[1]), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("mid_reset", 1);
    repeat (3) @(negedge clk);
    chk_zero("post_reset_idle", 1);

    cur = 101;
    run('{1'b1, 32'h5A5A_0F0F, 0, 0, 144, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
